// File: rtl/gaze_sched.sv
// Gaze direction scheduler: manual jog requests take priority over an automatic
// right/down/left/up raster scan that starts after a programmable idle period.
`timescale 1ns/1ps
module gaze_sched #(
    parameter int unsigned IDLE_MS = 2000,
    parameter int unsigned STEP_MS = 20,
    parameter int unsigned STEP_N  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1khz,
    input  logic       auto_en,
    input  logic       man_left,
    input  logic       man_right,
    input  logic       man_up,
    input  logic       man_down,
    output logic       left_dir,
    output logic       right_dir,
    output logic       up_dir,
    output logic       down_dir,
    output logic [1:0] mode,
    output logic [1:0] scan_leg
);
    localparam int unsigned IW = $clog2(IDLE_MS + 1);
    localparam int unsigned TW = $clog2(STEP_MS + 1);
    localparam int unsigned SW = $clog2(STEP_N + 1);
    localparam logic [IW-1:0] IdleLast = IW'(IDLE_MS - 1);
    localparam logic [TW-1:0] TickLast = TW'(STEP_MS - 1);
    localparam logic [SW-1:0] StepLast = SW'(STEP_N - 1);

    typedef enum logic [1:0] {StIdle = 2'b00, StManual = 2'b01, StScan = 2'b10} state_e;

    state_e        state_q, state_d;
    logic [3:0]    man_s1_q, man_s2_q;   // {left, right, up, down}
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]    leg_q, leg_d;
    logic [3:0]    dir_q, dir_d;         // {left, right, up, down}
    logic          manual;
    logic [3:0]    man_dir;
    logic [3:0]    leg_dir;

    assign manual  = |man_s2_q;
    // Opposing requests on one axis cancel that axis only.
    assign man_dir = {man_s2_q[3] & ~man_s2_q[2], man_s2_q[2] & ~man_s2_q[3],
                      man_s2_q[1] & ~man_s2_q[0], man_s2_q[0] & ~man_s2_q[1]};

    always_comb begin
        leg_dir = 4'b0000;
        unique case (leg_q)
            2'd0: leg_dir = 4'b0100;
            2'd1: leg_dir = 4'b0001;
            2'd2: leg_dir = 4'b1000;
            2'd3: leg_dir = 4'b0010;
            default: leg_dir = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (manual) begin
                    state_d = StManual;
                end else if (tick_1khz && auto_en && idle_cnt_q == IdleLast) begin
                    state_d = StScan;
                end
            end
            StManual: if (!manual) state_d = StIdle;
            StScan: begin
                if (manual) begin
                    state_d = StManual;
                end else if (!auto_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        tick_cnt_d = tick_cnt_q;
        step_cnt_d = step_cnt_q;
        leg_d      = leg_q;
        dir_d      = 4'b0000;
        unique case (state_q)
            StIdle: begin
                tick_cnt_d = '0;
                step_cnt_d = '0;
                if (manual) begin
                    idle_cnt_d = idle_cnt_q;
                end else if (!auto_en) begin
                    idle_cnt_d = '0;
                end else if (tick_1khz) begin
                    if (idle_cnt_q == IdleLast) begin
                        idle_cnt_d = '0;
                        leg_d      = 2'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
            end
            StManual: begin
                if (!manual) begin
                    idle_cnt_d = '0;
                    tick_cnt_d = '0;
                end else if (tick_1khz) begin
                    // Pulse on the tick where the count sits at zero, i.e. the first one.
                    if (tick_cnt_q == '0) dir_d = man_dir;
                    tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TW'(1);
                end
            end
            StScan: begin
                if (manual) begin
                    tick_cnt_d = '0;
                end else if (!auto_en) begin
                    idle_cnt_d = '0;
                    tick_cnt_d = '0;
                end else if (tick_1khz) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        dir_d      = leg_dir;
                        if (step_cnt_q == StepLast) begin
                            step_cnt_d = '0;
                            leg_d      = leg_q + 2'd1;
                        end else begin
                            step_cnt_d = step_cnt_q + SW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: begin
                idle_cnt_d = '0;
                tick_cnt_d = '0;
                step_cnt_d = '0;
                leg_d      = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            man_s1_q   <= 4'b0000;
            man_s2_q   <= 4'b0000;
            idle_cnt_q <= '0;
            tick_cnt_q <= '0;
            step_cnt_q <= '0;
            leg_q      <= 2'd0;
            dir_q      <= 4'b0000;
        end else begin
            man_s1_q   <= {man_left, man_right, man_up, man_down};
            man_s2_q   <= man_s1_q;
            idle_cnt_q <= idle_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            step_cnt_q <= step_cnt_d;
            leg_q      <= leg_d;
            dir_q      <= dir_d;
        end
    end

    assign {left_dir, right_dir, up_dir, down_dir} = dir_q;
    assign mode     = state_q;
    assign scan_leg = leg_q;

endmodule

// File: tb/tb_gaze_sched.sv
// Directed bench for gaze_sched with IDLE_MS=4, STEP_MS=2, STEP_N=3.
`timescale 1ns/1ps
module tb_gaze_sched;
    logic       clk = 1'b0;
    logic       rst, tick_1khz, auto_en;
    logic       man_left, man_right, man_up, man_down;
    logic       left_dir, right_dir, up_dir, down_dir;
    logic [1:0] mode, scan_leg;
    logic [3:0] dirs;
    int         total = 0;
    int         bad   = 0;

    gaze_sched #(.IDLE_MS(4), .STEP_MS(2), .STEP_N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1khz (tick_1khz),
        .auto_en   (auto_en),
        .man_left  (man_left),
        .man_right (man_right),
        .man_up    (man_up),
        .man_down  (man_down),
        .left_dir  (left_dir),
        .right_dir (right_dir),
        .up_dir    (up_dir),
        .down_dir  (down_dir),
        .mode      (mode),
        .scan_leg  (scan_leg)
    );

    always #5 clk = ~clk;
    assign dirs = {left_dir, right_dir, up_dir, down_dir};

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-clock tick strobe; returns #1 after the edge that samples it.
    task automatic do_tick();
        @(negedge clk);
        tick_1khz = 1'b1;
        @(posedge clk);
        #1;
        tick_1khz = 1'b0;
    endtask

    function automatic logic [3:0] leg_map(input int leg);
        case (leg % 4)
            0: return 4'b0100;
            1: return 4'b0001;
            2: return 4'b1000;
            default: return 4'b0010;
        endcase
    endfunction

    // Scan-phase expectations, t counted in ticks since the fresh idle start.
    function automatic logic [3:0] scan_dir(input int t);
        if (t >= 6 && t % 2 == 0) return leg_map((t - 6) / 6);
        return 4'b0000;
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; tick_1khz = 1'b0; auto_en = 1'b0;
        man_left = 1'b0; man_right = 1'b0; man_up = 1'b0; man_down = 1'b0;
        clk_n(3);
        check("reset_mode", {2'b00, mode}, 4'b0000);
        check("reset_leg", {2'b00, scan_leg}, 4'b0000);
        check("reset_dirs", dirs, 4'b0000);
        rst = 1'b0;
        clk_n(2);

        // Manual right held for five ticks.
        man_right = 1'b1;
        clk_n(3);
        check("man_r_mode", {2'b00, mode}, 4'b0001);
        for (int i = 1; i <= 5; i++) begin
            do_tick();
            check("man_r_pulse", dirs, (i % 2 == 1) ? 4'b0100 : 4'b0000);
        end
        man_right = 1'b0;
        clk_n(3);
        check("man_r_release", {2'b00, mode}, 4'b0000);

        // Left+right cancel; up still pulses.
        man_left = 1'b1; man_right = 1'b1; man_up = 1'b1;
        clk_n(3);
        check("man_lru_mode", {2'b00, mode}, 4'b0001);
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            check("man_lru_pulse", dirs, (i % 2 == 1) ? 4'b0010 : 4'b0000);
        end
        man_left = 1'b0; man_right = 1'b0; man_up = 1'b0;
        clk_n(3);
        check("man_lru_release", {2'b00, mode}, 4'b0000);

        // Full automatic scan through all four legs.
        auto_en = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            do_tick();
            check("scan_mode", {2'b00, mode}, (t >= 4) ? 4'b0010 : 4'b0000);
            check("scan_leg", {2'b00, scan_leg}, (t >= 4) ? 4'(((t - 4) / 6) % 4) : 4'b0000);
            check("scan_dir", dirs, scan_dir(t));
            if (scan_dir(t) != 4'b0000) begin
                clk_n(1);
                check("scan_width", dirs, 4'b0000);
            end
        end

        // Drop auto_en on the tick that would pulse right.
        do_tick();
        check("t29_dir", dirs, 4'b0000);
        auto_en = 1'b0;
        do_tick();
        check("drop_mode", {2'b00, mode}, 4'b0000);
        check("drop_dir", dirs, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("hold_idle", {2'b00, mode} | dirs, 4'b0000);
        end
        auto_en = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            do_tick();
            check("rescan_mode", {2'b00, mode}, (t >= 4) ? 4'b0010 : 4'b0000);
            check("rescan_dir", dirs, scan_dir(t));
        end
        rst = 1'b1;
        clk_n(1);
        check("rst_dirs", dirs, 4'b0000);
        check("rst_mode", {2'b00, mode}, 4'b0000);
        check("rst_leg", {2'b00, scan_leg}, 4'b0000);
        rst = 1'b0;
        clk_n(1);

        // Manual down collides with a scan pulse in leg 1.
        for (int t = 1; t <= 13; t++) begin
            do_tick();
            if (t == 12) check("pre_man_dir", dirs, 4'b0001);
        end
        check("pre_man_leg", {2'b00, scan_leg}, 4'b0001);
        man_down = 1'b1;
        clk_n(2);
        check("sync_lat_mode", {2'b00, mode}, 4'b0010);
        do_tick();
        check("collide_mode", {2'b00, mode}, 4'b0001);
        check("collide_dir", dirs, 4'b0000);
        do_tick();
        check("man_d_pulse", dirs, 4'b0001);
        man_down = 1'b0;
        clk_n(3);
        check("man_d_release", {2'b00, mode}, 4'b0000);
        for (int t = 1; t <= 6; t++) begin
            do_tick();
            if (t == 4) check("new_scan_leg", {2'b00, scan_leg}, 4'b0000);
            if (t == 4) check("new_scan_mode", {2'b00, mode}, 4'b0010);
            if (t == 6) check("new_scan_dir", dirs, 4'b0100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
